// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle sequencer and the shared MIPS datapath.
// Latency: none, wires only.
// Backpressure: mem_ready from the memory side throttles the sequencer.
interface multicycle_ctrl_if;
    // Instruction fields and datapath status
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    // Datapath control
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic       alu_src_b;
    logic       ext_op;
    logic [3:0] alu_op;
    logic [1:0] ld_size;
    logic       ld_unsigned;
    logic       instr_done;
    logic       illegal;
    logic [2:0] state;

    // Sequencer side
    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_b, ext_op, alu_op,
               ld_size, ld_unsigned, instr_done, illegal, state
    );

    // Datapath / memory side
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_b, ext_op, alu_op,
               ld_size, ld_unsigned, instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer stepping one ALU + one unified memory port through FETCH/DECODE/EXEC/MEMACC/WB; SUBWORD_MEM_EN adds lb/lh/lbu/lhu/sb/sh.
// Latency: jumps 2, branches 3, ALU ops and stores 4, loads 5 cycles, plus one per wait cycle.
// Backpressure: FETCH and MEMACC hold with mem_req high until mem_ready; mem_ready is ignored elsewhere.
module multicycle_ctrl #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    // Instruction classes resolved once from opcode/funct
    typedef enum logic [3:0] {
        C_ILL, C_J, C_JAL, C_JR, C_JALR, C_RALU, C_IALU, C_BR, C_LOAD, C_STORE
    } cls_t;

    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    // Shift encodings occupy otherwise unused ALU codes
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
    localparam logic [3:0] ALU_NOR  = 4'b1110;

    localparam logic [1:0] PC_INC  = 2'b00;
    localparam logic [1:0] PC_BR   = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_RS   = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_RA  = 2'b10;

    localparam logic [1:0] SZ_WORD = 2'b00;
`ifdef SUBWORD_MEM_EN
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
`endif

    state_t     state_q, state_d;

    cls_t       dec_cls;
    logic [3:0] dec_alu_op;
    logic       dec_alu_src_b;
    logic       dec_ext_op;
    logic [1:0] dec_ld_size;
    logic       dec_ld_unsigned;
    logic       branch_taken;

    // Instruction decode: class plus the ALU/extension/size fields it implies
    always_comb begin
        dec_cls         = C_ILL;
        dec_alu_op      = 4'b0000;
        dec_alu_src_b   = 1'b0;
        dec_ext_op      = 1'b0;
        dec_ld_size     = SZ_WORD;
        dec_ld_unsigned = 1'b0;
        case (bus.opcode)
            6'b000000: begin
                dec_cls = C_RALU;
                case (bus.funct)
                    6'b000000, 6'b000100: dec_alu_op = ALU_SLL;
                    6'b000010, 6'b000110: dec_alu_op = ALU_SRL;
                    6'b000011, 6'b000111: dec_alu_op = ALU_SRA;
                    6'b001000:            dec_cls    = C_JR;
                    6'b001001:            dec_cls    = C_JALR;
                    6'b100000, 6'b100001: dec_alu_op = ALU_ADD;
                    6'b100010, 6'b100011: dec_alu_op = ALU_SUB;
                    6'b100100:            dec_alu_op = ALU_AND;
                    6'b100101:            dec_alu_op = ALU_OR;
                    6'b100110:            dec_alu_op = ALU_XOR;
                    6'b100111:            dec_alu_op = ALU_NOR;
                    6'b101010:            dec_alu_op = ALU_SLT;
                    6'b101011:            dec_alu_op = ALU_SLTU;
                    default:              dec_cls    = C_ILL;
                endcase
            end
            6'b000010: dec_cls = C_J;
            6'b000011: dec_cls = C_JAL;
            6'b000100, 6'b000101: begin
                dec_cls    = C_BR;
                dec_alu_op = ALU_SUB;
                dec_ext_op = 1'b1;
            end
            6'b001000: begin
                dec_cls = C_IALU; dec_alu_op = ALU_ADD; dec_alu_src_b = 1'b1; dec_ext_op = 1'b1;
            end
            6'b001010: begin
                dec_cls = C_IALU; dec_alu_op = ALU_SLT; dec_alu_src_b = 1'b1; dec_ext_op = 1'b1;
            end
            6'b001100: begin
                dec_cls = C_IALU; dec_alu_op = ALU_AND; dec_alu_src_b = 1'b1;
            end
            6'b001101: begin
                dec_cls = C_IALU; dec_alu_op = ALU_OR;  dec_alu_src_b = 1'b1;
            end
            6'b001111: begin
                dec_cls = C_IALU; dec_alu_op = ALU_LUI; dec_alu_src_b = 1'b1;
            end
            6'b100011: begin
                dec_cls = C_LOAD;  dec_alu_op = ALU_ADD; dec_alu_src_b = 1'b1; dec_ext_op = 1'b1;
            end
            6'b101011: begin
                dec_cls = C_STORE; dec_alu_op = ALU_ADD; dec_alu_src_b = 1'b1; dec_ext_op = 1'b1;
            end
`ifdef SUBWORD_MEM_EN
            6'b100000, 6'b100001, 6'b100100, 6'b100101: begin
                // bit 0 selects half vs byte, bit 2 selects unsigned
                dec_cls         = C_LOAD;
                dec_alu_op      = ALU_ADD;
                dec_alu_src_b   = 1'b1;
                dec_ext_op      = 1'b1;
                dec_ld_size     = bus.opcode[0] ? SZ_HALF : SZ_BYTE;
                dec_ld_unsigned = bus.opcode[2];
            end
            6'b101000, 6'b101001: begin
                dec_cls       = C_STORE;
                dec_alu_op    = ALU_ADD;
                dec_alu_src_b = 1'b1;
                dec_ext_op    = 1'b1;
                dec_ld_size   = bus.opcode[0] ? SZ_HALF : SZ_BYTE;
            end
`endif
            default: dec_cls = C_ILL;
        endcase
    end

    // bne is opcode 000101, beq 000100: bit 0 inverts the zero test
    assign branch_taken = bus.opcode[0] ? ~bus.zero : bus.zero;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs from the current state and decoded instruction
    always_comb begin
        state_d         = state_q;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = PC_INC;
        bus.reg_write   = 1'b0;
        bus.reg_dst     = DST_RT;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_b   = 1'b0;
        bus.ext_op      = 1'b0;
        bus.alu_op      = 4'b0000;
        bus.ld_size     = SZ_WORD;
        bus.ld_unsigned = 1'b0;
        bus.instr_done  = 1'b0;
        bus.illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                // IR and PC+4 commit only on the completing cycle
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PC_INC;
                    state_d      = S_DECODE;
                end
            end

            S_DECODE: begin
                case (dec_cls)
                    C_J: begin
                        bus.pc_write   = 1'b1;
                        bus.pc_src     = PC_JMP;
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    C_JAL: begin
                        bus.pc_write   = 1'b1;
                        bus.pc_src     = PC_JMP;
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = DST_RA;
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    C_JR: begin
                        bus.pc_write   = 1'b1;
                        bus.pc_src     = PC_RS;
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    C_JALR: begin
                        bus.pc_write   = 1'b1;
                        bus.pc_src     = PC_RS;
                        bus.reg_write  = 1'b1;
                        bus.reg_dst    = DST_RD;
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    C_ILL:   state_d = S_TRAP;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                bus.alu_op      = dec_alu_op;
                bus.alu_src_b   = dec_alu_src_b;
                bus.ext_op      = dec_ext_op;
                bus.ld_size     = dec_ld_size;
                bus.ld_unsigned = dec_ld_unsigned;
                case (dec_cls)
                    C_BR: begin
                        if (branch_taken) begin
                            bus.pc_write = 1'b1;
                            bus.pc_src   = PC_BR;
                        end
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                    C_LOAD, C_STORE: state_d = S_MEMACC;
                    C_RALU, C_IALU:  state_d = S_WB;
                    default:         state_d = S_TRAP;
                endcase
            end

            S_MEMACC: begin
                bus.mem_req     = 1'b1;
                bus.iord        = 1'b1;
                bus.mem_we      = (dec_cls == C_STORE);
                bus.alu_op      = dec_alu_op;
                bus.alu_src_b   = dec_alu_src_b;
                bus.ext_op      = dec_ext_op;
                bus.ld_size     = dec_ld_size;
                bus.ld_unsigned = dec_ld_unsigned;
                if (bus.mem_ready) begin
                    if (dec_cls == C_STORE) begin
                        bus.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end else begin
                        state_d        = S_WB;
                    end
                end
            end

            S_WB: begin
                bus.reg_write   = 1'b1;
                bus.instr_done  = 1'b1;
                bus.reg_dst     = (dec_cls == C_RALU) ? DST_RD : DST_RT;
                bus.mem_to_reg  = (dec_cls == C_LOAD);
                bus.alu_op      = dec_alu_op;
                bus.alu_src_b   = dec_alu_src_b;
                bus.ext_op      = dec_ext_op;
                bus.ld_size     = dec_ld_size;
                bus.ld_unsigned = dec_ld_unsigned;
                state_d         = S_FETCH;
            end

            S_TRAP: begin
                bus.illegal = 1'b1;
            end

            default: state_d = S_TRAP;
        endcase

        // Reset masks every strobe, including a store caught mid-MEMACC
        if (rst) begin
            bus.mem_req    = 1'b0;
            bus.mem_we     = 1'b0;
            bus.ir_write   = 1'b0;
            bus.pc_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.instr_done = 1'b0;
            bus.illegal    = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-scenario tasks with hand-computed expectations.
// Latency: checks taken 1-2 ns after each rising edge.
// Backpressure: mem_ready driven low in FETCH/MEMACC to exercise waits.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] got;
    logic [31:0] exp;
    int          checks;
    int          errors;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.RESET_STATE(3'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        got = 32'({bus.state, bus.mem_req, bus.ir_write, bus.pc_write, bus.reg_write,
                   bus.mem_we, bus.instr_done, bus.illegal, bus.ld_size});
        exp = 32'({3'd0, 7'b0, 2'b00});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", got, exp); end
        rst = 1'b0;
        #1;
        got = 32'({bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src});
        exp = 32'({3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", got, exp); end
    endtask

    task automatic test_add();
        bus.opcode = 6'b000000; bus.funct = 6'b100000; bus.mem_ready = 1'b1;
        tick();
        got = 32'({bus.state, bus.mem_req, bus.pc_write, bus.reg_write, bus.instr_done});
        exp = 32'({3'd1, 4'b0000});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL add_decode got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.instr_done, bus.pc_write});
        exp = 32'({3'd2, 1'b0, 4'b0001, 3'b000});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL add_exec got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.reg_write, bus.reg_dst, bus.alu_op, bus.mem_to_reg, bus.instr_done});
        exp = 32'({3'd4, 1'b1, 2'b01, 4'b0001, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL add_wb got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.instr_done, bus.mem_req});
        exp = 32'({3'd0, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL add_return got=%h exp=%h", got, exp); end
    endtask

    task automatic test_lw_wait();
        bus.opcode = 6'b100011; bus.mem_ready = 1'b1;
        tick();
        tick();
        got = 32'({bus.state, bus.alu_op, bus.alu_src_b, bus.ext_op});
        exp = 32'({3'd2, 4'b0001, 1'b1, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL lw_exec got=%h exp=%h", got, exp); end
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0 || i == 1) tick();
            if (i == 2) begin bus.mem_ready = 1'b1; #1; end
            got = 32'({bus.state, bus.mem_req, bus.iord, bus.mem_we, bus.instr_done});
            exp = 32'({3'd3, 1'b1, 1'b1, 1'b0, 1'b0});
            checks++;
            if (got !== exp) begin errors++; $display("FAIL lw_memacc_%0d got=%h exp=%h", i, got, exp); end
        end
        tick();
        got = 32'({bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.instr_done});
        exp = 32'({3'd4, 1'b1, 1'b1, 2'b00, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL lw_wb got=%h exp=%h", got, exp); end
        tick();
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL lw_return got=%h exp=0", bus.state); end
    endtask

    task automatic test_store_fetch_wait();
        bus.opcode = 6'b101011; bus.mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            got = 32'({bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write});
            exp = 32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
            checks++;
            if (got !== exp) begin errors++; $display("FAIL sw_fetch_wait_%0d got=%h exp=%h", i, got, exp); end
            if (i == 0) tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        got = 32'({bus.state, bus.mem_req, bus.ir_write, bus.pc_write});
        exp = 32'({3'd0, 1'b1, 1'b1, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sw_fetch_done got=%h exp=%h", got, exp); end
        tick();
        tick();
        tick();
        got = 32'({bus.state, bus.mem_req, bus.iord, bus.mem_we, bus.ld_size, bus.instr_done});
        exp = 32'({3'd3, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sw_memacc got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.mem_we});
        exp = 32'({3'd0, 1'b0});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sw_return got=%h exp=%h", got, exp); end
    endtask

    task automatic test_branch();
        bus.opcode = 6'b000100; bus.zero = 1'b1;
        tick();
        tick();
        got = 32'({bus.state, bus.alu_op, bus.alu_src_b, bus.pc_write, bus.pc_src, bus.instr_done});
        exp = 32'({3'd2, 4'b0010, 1'b0, 1'b1, 2'b01, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL beq_taken got=%h exp=%h", got, exp); end
        tick();
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL beq_taken_return got=%h exp=0", bus.state); end
        bus.zero = 1'b0;
        tick();
        tick();
        got = 32'({bus.state, bus.pc_write, bus.instr_done});
        exp = 32'({3'd2, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL beq_not_taken got=%h exp=%h", got, exp); end
        tick();
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL beq_nt_return got=%h exp=0", bus.state); end
        bus.opcode = 6'b000101;
        tick();
        tick();
        got = 32'({bus.state, bus.pc_write, bus.pc_src});
        exp = 32'({3'd2, 1'b1, 2'b01});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL bne_taken got=%h exp=%h", got, exp); end
        tick();
    endtask

    task automatic test_jumps();
        bus.opcode = 6'b000011;
        tick();
        got = 32'({bus.state, bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dst, bus.instr_done});
        exp = 32'({3'd1, 1'b1, 2'b10, 1'b1, 2'b10, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL jal_decode got=%h exp=%h", got, exp); end
        tick();
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL jal_return got=%h exp=0", bus.state); end
        bus.opcode = 6'b000000; bus.funct = 6'b001000;
        tick();
        got = 32'({bus.state, bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dst, bus.instr_done});
        exp = 32'({3'd1, 1'b1, 2'b11, 1'b0, 2'b00, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL jr_decode got=%h exp=%h", got, exp); end
        tick();
        bus.funct = 6'b001001;
        tick();
        got = 32'({bus.state, bus.pc_write, bus.pc_src, bus.reg_write, bus.reg_dst, bus.instr_done});
        exp = 32'({3'd1, 1'b1, 2'b11, 1'b1, 2'b01, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL jalr_decode got=%h exp=%h", got, exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.opcode = 6'b001101;
        tick();
        tick();
        got = 32'({bus.state, bus.alu_src_b, bus.ext_op, bus.alu_op});
        exp = 32'({3'd2, 1'b1, 1'b0, 4'b0100});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ori_exec got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done});
        exp = 32'({3'd4, 1'b1, 2'b00, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL ori_wb got=%h exp=%h", got, exp); end
        bus.opcode = 6'b000010;
        tick();
        got = 32'({bus.state, bus.pc_write, bus.ir_write, bus.instr_done});
        exp = 32'({3'd0, 1'b1, 1'b1, 1'b0});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_fetch got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.pc_write, bus.pc_src, bus.reg_write, bus.instr_done});
        exp = 32'({3'd1, 1'b1, 2'b10, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL j_decode got=%h exp=%h", got, exp); end
        tick();
    endtask

    task automatic test_reset_mid_store();
        bus.opcode = 6'b101011;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        got = 32'({bus.state, bus.mem_req, bus.mem_we});
        exp = 32'({3'd3, 1'b1, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_store_pending got=%h exp=%h", got, exp); end
        rst = 1'b1;
        #1;
        got = 32'({bus.mem_req, bus.mem_we, bus.instr_done, bus.pc_write, bus.reg_write,
                   bus.ir_write, bus.illegal});
        exp = 32'(7'b0);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_store_mask got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.mem_req, bus.ld_size});
        exp = 32'({3'd0, 1'b0, 2'b00});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_store_edge got=%h exp=%h", got, exp); end
        rst = 1'b0; bus.mem_ready = 1'b1;
        #1;
        got = 32'({bus.state, bus.mem_req});
        exp = 32'({3'd0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_store_release got=%h exp=%h", got, exp); end
    endtask

    task automatic test_subword();
        bus.opcode = 6'b101000;
        tick();
        tick();
`ifdef SUBWORD_MEM_EN
        got = 32'({bus.state, bus.alu_op, bus.alu_src_b, bus.ld_size});
        exp = 32'({3'd2, 4'b0001, 1'b1, 2'b10});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sb_exec got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.mem_we, bus.mem_req, bus.ld_size, bus.ld_unsigned, bus.instr_done});
        exp = 32'({3'd3, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sb_memacc got=%h exp=%h", got, exp); end
        tick();
        bus.opcode = 6'b100101;
        tick();
        tick();
        tick();
        got = 32'({bus.state, bus.mem_we, bus.ld_size, bus.ld_unsigned});
        exp = 32'({3'd3, 1'b0, 2'b01, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL lhu_memacc got=%h exp=%h", got, exp); end
        tick();
        got = 32'({bus.state, bus.mem_to_reg, bus.ld_size, bus.ld_unsigned});
        exp = 32'({3'd4, 1'b1, 2'b01, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL lhu_wb got=%h exp=%h", got, exp); end
        tick();
`else
        got = 32'({bus.state, bus.illegal, bus.ld_size, bus.ld_unsigned, bus.mem_req});
        exp = 32'({3'd5, 1'b1, 2'b00, 1'b0, 1'b0});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sb_trap got=%h exp=%h", got, exp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.opcode = 6'b100100;
        tick();
        tick();
        got = 32'({bus.state, bus.illegal, bus.ld_unsigned});
        exp = 32'({3'd5, 1'b1, 1'b0});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL lbu_trap got=%h exp=%h", got, exp); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        checks++;
        if (bus.state !== 3'd0) begin errors++; $display("FAIL subword_return got=%h exp=0", bus.state); end
    endtask

    task automatic test_trap();
        bus.opcode = 6'b111111;
        tick();
        got = 32'({bus.state, bus.pc_write, bus.reg_write, bus.instr_done});
        exp = 32'({3'd1, 3'b000});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL trap_decode got=%h exp=%h", got, exp); end
        tick();
        for (int i = 0; i < 10; i++) begin
            got = 32'({bus.state, bus.illegal, bus.mem_req, bus.mem_we, bus.ir_write,
                       bus.pc_write, bus.reg_write, bus.instr_done});
            exp = 32'({3'd5, 1'b1, 6'b000000});
            checks++;
            if (got !== exp) begin errors++; $display("FAIL trap_hold_%0d got=%h exp=%h", i, got, exp); end
            tick();
        end
        rst = 1'b1;
        #1;
        got = 32'({bus.state, bus.illegal});
        exp = 32'({3'd5, 1'b0});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL trap_rst_mask got=%h exp=%h", got, exp); end
        tick();
        rst = 1'b0;
        bus.opcode = 6'b000000;
        #1;
        got = 32'({bus.state, bus.illegal, bus.mem_req});
        exp = 32'({3'd0, 1'b0, 1'b1});
        checks++;
        if (got !== exp) begin errors++; $display("FAIL trap_cleared got=%h exp=%h", got, exp); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.opcode    = 6'b000000;
        bus.funct     = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        test_reset();
        test_add();
        test_lw_wait();
        test_store_fetch_wait();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_reset_mid_store();
        test_subword();
        test_trap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencing controller for the MIPS core: replaces single-cycle decode with an FSM that steps a shared datapath (one ALU, one unified instruction/data memory port) through fetch, decode, execute, memory and write-back. It sits between the instruction register and the datapath muxes/enables. It throttles fetch and memory-access phases on a memory ready handshake, so the same datapath works with wait-stated memory.

## Interface
Parameters:
- RESET_STATE, 3'd0, encoding loaded on reset (FETCH); not intended to change.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- opcode  in  6  IR[31:26], stable from DECODE until next FETCH completes
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualified by mem_req
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr/jalr)
- reg_write  out  1  register-file write
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  1  write-back source: 1 memory data, 0 ALUOut (link writes use PC+4 via reg_dst=10)
- alu_src_b  out  1  0 rt, 1 extended immediate
- ext_op  out  1  1 sign-extend, 0 zero-extend
- alu_op  out  4  0001 add, 0010 sub, 0011 and, 0100 or, 0101 slt, 0110 sltu, 1100 lui, 1101 xor, 1110 nor
- ld_size  out  2  00 word, 01 half, 10 byte (loads and stores)
- ld_unsigned  out  1  zero-extend sub-word load
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  high while in TRAP
- state  out  3  current state, for debug

## Operation
- States: FETCH(0), DECODE(1), EXEC(2), MEMACC(3), WB(4), TRAP(5). Outputs are combinational from the registered state plus opcode/funct/zero/mem_ready. Unlisted strobes are 0.
- FETCH: mem_req=1, iord=0. Hold while mem_ready=0. On mem_ready=1, assert ir_write=1, pc_write=1, pc_src=00 in the same cycle, then go to DECODE.
- DECODE:
  - j: pc_write=1, pc_src=10, go to FETCH.
  - jal: also reg_write=1, reg_dst=10.
  - jr: pc_write=1, pc_src=11, go to FETCH.
  - jalr: pc_src=11, reg_write=1, reg_dst=01.
  - Each of these asserts instr_done.
  - Undecodable opcode/funct: go to TRAP.
  - Anything else: go to EXEC.
- EXEC:
  - R-type ALU ops and shifts: alu_src_b=0, alu_op per funct, go to WB.
  - addi/slti/andi/ori/lui: alu_src_b=1, go to WB. ext_op=1 for addi/slti and memory ops, 0 for andi/ori/lui.
  - beq/bne: alu_op=0010. pc_write=1 and pc_src=01 only if taken (beq&zero, bne&~zero). instr_done=1, go to FETCH.
  - Loads/stores: alu_op=0001, alu_src_b=1, go to MEMACC.
- MEMACC: mem_req=1, iord=1, mem_we=1 for stores. Hold while mem_ready=0. On mem_ready, a store asserts instr_done and goes to FETCH; a load goes to WB.
- WB: reg_write=1, instr_done=1, go to FETCH.
  - Loads: mem_to_reg=1, reg_dst=00.
  - R-type: reg_dst=01.
  - I-type ALU: reg_dst=00.
- TRAP: illegal=1, all strobes 0, stays until rst.
- rst high: state goes to FETCH at the edge. While rst is high, every output strobe is forced to 0 (mem_req, ir_write, pc_write, reg_write, mem_we, instr_done, illegal). This applies regardless of state, including reset mid-MEMACC with a store pending. ld_size=00 and state reads 0 after the edge.

## Timing
- Latency with zero wait states:
  - j/jal/jr/jalr: 2 cycles.
  - Branch: 3 cycles.
  - R/I ALU and store: 4 cycles.
  - Load: 5 cycles.
- Each cycle of mem_ready=0 in FETCH or MEMACC adds one cycle. mem_ready is ignored in all other states.
- mem_req stays high continuously through a waited access. The memory must not see a drop between request and ready.
- pc_write/ir_write occur only in the mem_ready cycle of FETCH, so PC+4 is committed exactly once per instruction.

## Configuration
- SUBWORD_MEM_EN defined: lb(100000), lh(100001), lbu(100100), lhu(100101), sb(101000) and sh(101001) decode as memory ops.
  - ld_size = 10 for byte, 01 for half.
  - ld_unsigned = 1 for lbu/lhu.
- Undefined: those opcodes go to TRAP from DECODE, and ld_size/ld_unsigned are tied to 0. Only lw/sw are supported.

## Test plan
- Reset, then add $3,$1,$2 with mem_ready tied 1: states 0→1→2→4→0. WB cycle has reg_write=1, reg_dst=01, alu_op=0001. instr_done pulses in cycle 4 only.
- lw with mem_ready low for 2 cycles in MEMACC: mem_req=1, iord=1 held for 3 cycles. 7 cycles total. WB has mem_to_reg=1.
- beq: with zero=1, EXEC has pc_write=1, pc_src=01. With zero=0, pc_write=0. Both return to FETCH after 3 cycles.
- jal: DECODE has pc_write=1, pc_src=10, reg_write=1, reg_dst=10, instr_done=1. Next cycle state=0.
- opcode 111111: TRAP with illegal=1, held for 10 cycles with no strobes. rst clears to FETCH.
- sb with SUBWORD_MEM_EN: MEMACC has mem_we=1, ld_size=10. Without the macro: TRAP after DECODE.
